pmp_csr_regfile: RTL

- Holds the architectural PMP CSR state (pmpcfg0/pmpcfg2, pmpaddr0..15) for RV64 and drives the per-entry configuration consumed by the PMP checker (conf_o -> conf_i, conf_addr_o -> conf_addr_i).
- Sits between the CSR access path and the PMP checker. Implements the WARL rules, lock semantics and read/write request/response timing.
- Emits an update pulse so downstream address-translation and PMP caches can flush.

---
 rtl/pmp_csr_regfile.sv | 75 +++++++
 1 files changed

// File: rtl/pmp_csr_regfile.sv
// pmp_csr_regfile: RV64 PMP CSR state (pmpcfg0/2, pmpaddr0..15) with WARL, lock rules and checker config outputs
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_*_i, priv_lvl_i   CSR access request (one per cycle, always accepted), requester privilege (2'b11 = M)
//   rsp_*_o               registered response one cycle after the request (read data or pre-write value)
//   conf_o                per-entry cfg byte {L, 2'b00, A[1:0], X, W, R}
//   conf_addr_o           per-entry stored pmpaddr (PLEN-2 bits)
//   pmp_update_o          one-cycle pulse when a write changed any stored bit
module pmp_csr_regfile #(
    parameter int NrPMPEntries = 16,
    parameter int PLEN         = 34
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   req_valid_i,
    input  logic                                   req_we_i,
    input  logic [11:0]                            req_addr_i,
    input  logic [63:0]                            req_wdata_i,
    input  logic [1:0]                             priv_lvl_i,
    output logic                                   rsp_valid_o,
    output logic [63:0]                            rsp_rdata_o,
    output logic                                   rsp_illegal_o,
    output logic [NrPMPEntries-1:0][7:0]           conf_o,
    output logic [NrPMPEntries-1:0][PLEN-3:0]      conf_addr_o,
    output logic                                   pmp_update_o
);
    localparam logic [1:0] PRIV_LVL_M = 2'b11;
    localparam logic [1:0] A_TOR      = 2'b01;
    logic [15:0][7:0]      cfg_q, cfg_d;
    logic [15:0][PLEN-3:0] addr_q, addr_d;
    logic [15:0]           tor_next;
    logic [7:0]            wb;
    logic                  is_cfg0, is_cfg2, is_addr, legal, wr;
    logic [63:0]           rdata;
    always_comb begin
        is_cfg0  = req_addr_i == 12'h3A0;
        is_cfg2  = req_addr_i == 12'h3A2;
        is_addr  = req_addr_i[11:4] == 8'h3B;
        legal    = priv_lvl_i == PRIV_LVL_M && (is_cfg0 || is_cfg2 || is_addr);
        wr       = req_valid_i && req_we_i && legal;
        rdata    = is_cfg0 ? cfg_q[7:0] : is_cfg2 ? cfg_q[15:8] : is_addr ? 64'(addr_q[req_addr_i[3:0]]) : '0;
        cfg_d    = cfg_q;
        addr_d   = addr_q;
        tor_next = '0;
        wb       = '0;
        for (int e = 0; e < 16; e++) begin
            // entry e+1 locked as TOR also freezes pmpaddr e (its lower bound)
            tor_next[e] = (e + 1 < NrPMPEntries) && cfg_q[(e+1)%16][7] && cfg_q[(e+1)%16][4:3] == A_TOR;
            wb = req_wdata_i[(e%8)*8 +: 8];
            // decisions use pre-write lock state; W without R keeps the whole byte
            if (wr && (e < 8 ? is_cfg0 : is_cfg2) && e < NrPMPEntries && !cfg_q[e][7] && wb[1:0] != 2'b10)
                cfg_d[e] = wb & 8'h9F;
            if (wr && is_addr && req_addr_i[3:0] == 4'(e) && e < NrPMPEntries && !cfg_q[e][7] && !tor_next[e])
                addr_d[e] = req_wdata_i[PLEN-3:0];
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_q         <= '0;
            addr_q        <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_illegal_o <= 1'b0;
            pmp_update_o  <= 1'b0;
        end else begin
            cfg_q         <= cfg_d;
            addr_q        <= addr_d;
            rsp_valid_o   <= req_valid_i;
            rsp_rdata_o   <= (req_valid_i && legal) ? rdata : '0;
            rsp_illegal_o <= req_valid_i && !legal;
            pmp_update_o  <= (cfg_d != cfg_q) || (addr_d != addr_q);
        end
    end
    assign conf_o      = cfg_q[NrPMPEntries-1:0];
    assign conf_addr_o = addr_q[NrPMPEntries-1:0];
endmodule
